// File: rtl/pn_lfsr_gen_param.sv
// pn_lfsr_gen_param: Fibonacci PN generator with seed load, lock-up recovery and period measurement
module pn_lfsr_gen_param #(
   parameter int               WIDTH    = 8,
   parameter logic [WIDTH-1:0] TAP_MASK = 8'hA0,
   parameter logic [WIDTH-1:0] SEED     = '1,
   parameter int               STEPS    = 1
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             en_i,
   input  logic             load_i,
   input  logic [WIDTH-1:0] seed_i,
   output logic [STEPS-1:0] pn_o,
   output logic [WIDTH-1:0] state_o,
   output logic             wrap_o,
   output logic [WIDTH-1:0] period_o,
   output logic             lockup_o,
   output logic             seed_err_o
);
   localparam logic [WIDTH:0] STEPS_X = (WIDTH+1)'(STEPS);
   logic [WIDTH-1:0] state_q, state_d, seed_q, seed_d, cnt_q, cnt_d, period_q, period_d;
   logic             wrap_q, wrap_d, lockup_q, lockup_d, seed_err_q, seed_err_d;
   logic [WIDTH-1:0] t, load_val;
   logic [STEPS-1:0] pn;
   logic             hit;
   logic [WIDTH:0]   j, sum_hit, sum_run, rem;
   // j is the first shift within this clock that lands back on the active seed
   always_comb begin
      t   = state_q;
      hit = 1'b0;
      j   = '0;
      pn  = '0;
      for (int k = 0; k < STEPS; k++) begin
         pn[k] = t[WIDTH-1];
         t     = {t[WIDTH-2:0], ^(t & TAP_MASK)};
         if (!hit && t == seed_q) begin
            hit = 1'b1;
            j   = (WIDTH+1)'(k + 1);
         end
      end
   end
   assign sum_hit  = {1'b0, cnt_q} + j;
   assign sum_run  = {1'b0, cnt_q} + STEPS_X;
   assign rem      = STEPS_X - j;
   assign load_val = (seed_i != '0) ? seed_i : SEED;
   always_comb begin
      state_d    = state_q;
      seed_d     = seed_q;
      cnt_d      = cnt_q;
      period_d   = period_q;
      seed_err_d = seed_err_q;
      wrap_d     = 1'b0;
      lockup_d   = 1'b0;
      if (load_i) begin
         state_d    = load_val;
         seed_d     = load_val;
         seed_err_d = (seed_i == '0);
         cnt_d      = '0;
      end else if (en_i && state_q == '0) begin
         state_d  = SEED;
         seed_d   = SEED;
         cnt_d    = '0;
         lockup_d = 1'b1;
      end else if (en_i) begin
         state_d  = t;
         wrap_d   = hit;
         period_d = hit ? (sum_hit[WIDTH] ? '1 : sum_hit[WIDTH-1:0]) : period_q;
         cnt_d    = hit ? rem[WIDTH-1:0] : (sum_run[WIDTH] ? '1 : sum_run[WIDTH-1:0]);
      end
   end
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q    <= SEED;
         seed_q     <= SEED;
         cnt_q      <= '0;
         period_q   <= '0;
         wrap_q     <= 1'b0;
         lockup_q   <= 1'b0;
         seed_err_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         seed_q     <= seed_d;
         cnt_q      <= cnt_d;
         period_q   <= period_d;
         wrap_q     <= wrap_d;
         lockup_q   <= lockup_d;
         seed_err_q <= seed_err_d;
      end
   end
   assign pn_o       = pn;
   assign state_o    = state_q;
   assign wrap_o     = wrap_q;
   assign period_o   = period_q;
   assign lockup_o   = lockup_q;
   assign seed_err_o = seed_err_q;
endmodule

// File: tb/tb_pn_lfsr_gen_param.sv
// tb_pn_lfsr_gen_param: vector table, directed corner sequences and a random model check
module tb_pn_lfsr_gen_param;
   logic clk, rst;
   int   n_cmp, n_bad;
   logic en0, ld0, en1, ld1, en3, ld3, en4, ld4;
   logic [7:0] sd0, sd3, st0, pd0, st3, pd3;
   logic [3:0] sd1, st1, pd1, st2, pd2;
   logic [5:0] sd4, st4, pd4;
   logic [0:0] pn0, pn1, pn3;
   logic [3:0] pn2, pn4;
   logic wr0, lk0, er0, wr1, lk1, er1, wr2, lk2, er2, wr3, lk3, er3, wr4, lk4, er4;

   pn_lfsr_gen_param u0 (.clk_i(clk), .reset_i(rst), .en_i(en0), .load_i(ld0), .seed_i(sd0),
      .pn_o(pn0), .state_o(st0), .wrap_o(wr0), .period_o(pd0), .lockup_o(lk0), .seed_err_o(er0));
   pn_lfsr_gen_param #(.WIDTH(4), .TAP_MASK(4'hC), .SEED(4'hF), .STEPS(1)) u1 (.clk_i(clk),
      .reset_i(rst), .en_i(en1), .load_i(ld1), .seed_i(sd1), .pn_o(pn1), .state_o(st1),
      .wrap_o(wr1), .period_o(pd1), .lockup_o(lk1), .seed_err_o(er1));
   pn_lfsr_gen_param #(.WIDTH(4), .TAP_MASK(4'hC), .SEED(4'hF), .STEPS(4)) u2 (.clk_i(clk),
      .reset_i(rst), .en_i(en1), .load_i(ld1), .seed_i(sd1), .pn_o(pn2), .state_o(st2),
      .wrap_o(wr2), .period_o(pd2), .lockup_o(lk2), .seed_err_o(er2));
   pn_lfsr_gen_param #(.WIDTH(8), .TAP_MASK(8'h20), .SEED(8'hFF), .STEPS(1)) u3 (.clk_i(clk),
      .reset_i(rst), .en_i(en3), .load_i(ld3), .seed_i(sd3), .pn_o(pn3), .state_o(st3),
      .wrap_o(wr3), .period_o(pd3), .lockup_o(lk3), .seed_err_o(er3));
   pn_lfsr_gen_param #(.WIDTH(6), .TAP_MASK(6'h30), .SEED(6'h3F), .STEPS(4)) u4 (.clk_i(clk),
      .reset_i(rst), .en_i(en4), .load_i(ld4), .seed_i(sd4), .pn_o(pn4), .state_o(st4),
      .wrap_o(wr4), .period_o(pd4), .lockup_o(lk4), .seed_err_o(er4));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic int sh6(input int s);
      return ((s << 1) & 63) | ($countones(s & 'h30) & 1);
   endfunction

   typedef struct {
      logic       en;
      logic       ld;
      logic [7:0] seed;
      logic [7:0] st;
      logic       pn;
      logic       err;
   } vec_t;
   vec_t tbl[16];

   bit q1[$], q2[$];
   int m_st, m_sd, m_c, m_pd, m_wr, m_lk, m_er, tt;
   logic [3:0] m_pn;
   logic [59:0] v1, v2;

   initial begin
      n_cmp = 0; n_bad = 0;
      rst = 1'b1;
      {en0, ld0, en1, ld1, en3, ld3, en4, ld4} = '0;
      sd0 = '0; sd1 = '0; sd3 = '0; sd4 = '0;
      tbl[0]  = '{1'b1, 1'b0, 8'h00, 8'hFE, 1'b1, 1'b0};
      tbl[1]  = '{1'b1, 1'b0, 8'h00, 8'hFC, 1'b1, 1'b0};
      tbl[2]  = '{1'b1, 1'b0, 8'h00, 8'hF8, 1'b1, 1'b0};
      tbl[3]  = '{1'b1, 1'b0, 8'h00, 8'hF0, 1'b1, 1'b0};
      tbl[4]  = '{1'b1, 1'b0, 8'h00, 8'hE0, 1'b1, 1'b0};
      tbl[5]  = '{1'b1, 1'b0, 8'h00, 8'hC0, 1'b1, 1'b0};
      tbl[6]  = '{1'b1, 1'b0, 8'h00, 8'h81, 1'b1, 1'b0};
      tbl[7]  = '{1'b1, 1'b0, 8'h00, 8'h03, 1'b0, 1'b0};
      tbl[8]  = '{1'b0, 1'b1, 8'h00, 8'hFF, 1'b1, 1'b1};
      tbl[9]  = '{1'b0, 1'b1, 8'h5A, 8'h5A, 1'b0, 1'b0};
      tbl[10] = '{1'b1, 1'b1, 8'h3C, 8'h3C, 1'b0, 1'b0};
      for (int i = 11; i < 16; i++) tbl[i] = '{1'b0, 1'b0, 8'h00, 8'h3C, 1'b0, 1'b0};
      #12;
      check("reset_state", st0, 8'hFF);
      check("reset_pn", pn0, 1'b1);
      check("reset_flags", {wr0, lk0, er0, pd0}, '0);
      rst = 1'b0;
      for (int i = 0; i < 16; i++) begin
         en0 = tbl[i].en; ld0 = tbl[i].ld; sd0 = tbl[i].seed;
         tick();
         check($sformatf("tbl%0d_state", i), st0, tbl[i].st);
         check($sformatf("tbl%0d_pn", i), pn0, tbl[i].pn);
         check($sformatf("tbl%0d_err", i), er0, tbl[i].err);
         check($sformatf("tbl%0d_wrap_period", i), {wr0, lk0, pd0}, '0);
      end
      en0 = 1'b0; ld0 = 1'b0;
      // 4-bit maximal sequence at one and four bits per clock
      en1 = 1'b1;
      for (int t = 1; t <= 60; t++) begin
         q1.push_back(pn1[0]);
         if (t <= 15) for (int b = 0; b < 4; b++) q2.push_back(pn2[b]);
         tick();
         check($sformatf("w4s1_wrap_t%0d", t), wr1, (t % 15) == 0);
         check($sformatf("w4s4_wrap_t%0d", t), wr2, (4 * t / 15) != (4 * (t - 1) / 15));
         if (t >= 15) check($sformatf("w4s1_period_t%0d", t), pd1, 4'd15);
         if (t >= 4) check($sformatf("w4s4_period_t%0d", t), pd2, 4'd15);
      end
      en1 = 1'b0;
      for (int i = 0; i < 60; i++) begin
         v1[i] = q1[i];
         v2[i] = q2[i];
      end
      check("stream_s1_vs_s4", v2, v1);
      // non-primitive mask falls into the all-zero state
      ld3 = 1'b1; sd3 = 8'h80;
      tick();
      check("lk_load", st3, 8'h80);
      ld3 = 1'b0; en3 = 1'b1;
      tick();
      check("lk_zero_state", st3, 8'h00);
      check("lk_zero_pulse", lk3, 1'b0);
      tick();
      check("lk_recover_state", st3, 8'hFF);
      check("lk_recover_pulse", lk3, 1'b1);
      tick();
      check("lk_after_state", st3, 8'hFF);
      check("lk_after_pulse", lk3, 1'b0);
      en3 = 1'b0;
      // random traffic against the reference model
      m_st = 63; m_sd = 63; m_c = 0; m_pd = 0; m_er = 0;
      for (int n = 0; n < 400; n++) begin
         en4 = ($urandom_range(0, 3) != 0);
         ld4 = ($urandom_range(0, 39) == 0);
         sd4 = ($urandom_range(0, 7) == 0) ? 6'd0 : 6'($urandom_range(1, 63));
         m_wr = 0; m_lk = 0;
         if (ld4) begin
            m_st = (sd4 != 0) ? int'(sd4) : 63;
            m_sd = m_st;
            m_er = (sd4 == 0);
            m_c = 0;
         end else if (en4 && m_st == 0) begin
            m_st = 63; m_sd = 63; m_c = 0; m_lk = 1;
         end else if (en4) begin
            for (int k = 0; k < 4; k++) begin
               m_st = sh6(m_st);
               m_c = (m_c < 63) ? m_c + 1 : 63;
               if (!m_wr && m_st == m_sd) begin
                  m_wr = 1; m_pd = m_c; m_c = 0;
               end
            end
         end
         tt = m_st;
         for (int k = 0; k < 4; k++) begin
            m_pn[k] = tt[5];
            tt = sh6(tt);
         end
         tick();
         check($sformatf("rnd%0d_state", n), st4, m_st);
         check($sformatf("rnd%0d_pn", n), pn4, m_pn);
         check($sformatf("rnd%0d_wrap", n), wr4, m_wr);
         check($sformatf("rnd%0d_period", n), pd4, m_pd);
         check($sformatf("rnd%0d_lockup", n), lk4, m_lk);
         check($sformatf("rnd%0d_err", n), er4, m_er);
      end
      // asynchronous reset in the middle of activity
      ld4 = 1'b0; en4 = 1'b1;
      ld0 = 1'b1; sd0 = 8'h00;
      tick();
      ld0 = 1'b0; en0 = 1'b1;
      tick();
      tick();
      #3 rst = 1'b1;
      #1;
      check("arst_state0", st0, 8'hFF);
      check("arst_err0", er0, 1'b0);
      check("arst_pn0", pn0, 1'b1);
      check("arst_state4", st4, 6'h3F);
      check("arst_flags4", {wr4, lk4, er4, pd4}, '0);
      #10 rst = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
